ld_str_reg_file: RTL and testbench
==================================

Name: ld_str_reg_file

Overview:
Parametrised multi-entry load/store register file for the 3-stage pipeline. It holds DEPTH words of WIDTH bits, with one write port and two registered read ports. Same-cycle write-to-read bypass is built in. A per-entry busy scoreboard lets the decode stage detect pending loads. It replaces banks of fixed 8-bit single-word load registers.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 8, number of entries (2..2**ADDR_W)
ADDR_W, 3, address width in bits
RESET_VAL, 0, value every entry takes on reset (WIDTH bits)
ZERO_REG, 0, when 1, entry 0 always reads 0 and ignores writes, set and locks

Ports:
clk  input  1  rising-edge clock
clr  input  1  asynchronous active-low reset
set  input  1  synchronous set: all entries become all-ones
ld_str  input  1  write enable
wr_addr  input  ADDR_W  write address
wr_data  input  WIDTH  write data
rd_addr_a  input  ADDR_W  read port A address
rd_addr_b  input  ADDR_W  read port B address
rd_data_a  output  WIDTH  registered read data, port A
rd_data_b  output  WIDTH  registered read data, port B
lock_en  input  1  mark entry lock_addr busy (pending load)
lock_addr  input  ADDR_W  entry to lock
busy_a  output  1  busy flag of entry rd_addr_a (combinational)
busy_b  output  1  busy flag of entry rd_addr_b (combinational)

Behaviour:
- Reset: clr=0 asynchronously forces every entry to RESET_VAL, rd_data_a/b to 0 and all busy bits to 0. ZERO_REG entry 0 is forced to 0. Reset held mid-operation discards any in-flight write or lock.
- Priority on each rising edge while clr=1: set > ld_str/lock_en > hold.
- set=1: every entry becomes {WIDTH{1'b1}} (entry 0 stays 0 if ZERO_REG). All busy bits clear. ld_str and lock_en are ignored that cycle.
- Write: when ld_str=1 and wr_addr<DEPTH, entry[wr_addr] <= wr_data and busy[wr_addr] <= 0.
- Out-of-range writes (wr_addr>=DEPTH) are ignored. Writes to entry 0 are ignored when ZERO_REG=1.
- Lock: when lock_en=1 and lock_addr<DEPTH, busy[lock_addr] <= 1.
- Lock and write to the same address in the same cycle: the data is written and busy ends at 1, so the new pending load wins.
- Read latency is 1 cycle. On each edge, rd_data_x <= the value the entry holds after that edge:
  - if set=1, the read returns all-ones (0 for entry 0 when ZERO_REG);
  - else if ld_str=1 and wr_addr==rd_addr_x and the write is in range, the read returns wr_data (write-through bypass);
  - else it returns the stored entry.
- rd_addr_x>=DEPTH returns 0. Both ports may address the same entry; both return identical data.
- busy_x = busy[rd_addr_x]. It is 0 for out-of-range addresses and for entry 0 when ZERO_REG=1. It has no bypass, so a same-cycle write clears busy only from the next cycle.
- All arithmetic is unsigned. Address compares use the full ADDR_W bits with no wrap.

Test Plan:
- Reset/defaults (WIDTH=8, DEPTH=8, RESET_VAL=8'h5A): pulse clr low mid-cycle -> all entries 8'h5A, rd_data 0 and busy 0 immediately. First reads after release return 8'h5A.
- Write then read: write 8'hC3 to addr 3, then read A=3 next cycle -> rd_data_a=8'hC3 one cycle later. Write 8'h11 to addr 5 with rd_addr_b=5 in the same cycle -> rd_data_b=8'h11 after that edge (bypass).
- Set priority: set=1 together with ld_str to addr 2 (data 8'h00) and lock_en addr 2 -> entry 2 = 8'hFF and busy[2]=0. With ZERO_REG=1, entry 0 reads 8'h00.
- Scoreboard: lock addr 4 -> busy_a=1 (rd_addr_a=4) next cycle. Write addr 4 -> busy_a=0 the cycle after. Lock and write addr 4 together -> data updated, busy_a stays 1.
- Bounds (DEPTH=6, ADDR_W=3): write 8'hAA to addr 7 -> no entry changes. Read addr 6 -> 0 and busy 0.
- Mid-operation reset: assert clr during ld_str to addr 1 -> entry 1 = RESET_VAL after release, not the write data.

Source files
------------

// File: rtl/ld_str_reg_file.sv
// ---------------------------------------------------------------------------
// ld_str_reg_file
//
// Multi-entry load/store register file for the 3-stage pipeline. It has one
// write port and two registered read ports. A read in the same cycle as a
// write to that entry sees the new data (write-through bypass). Each entry
// carries a busy bit that marks a pending load for the decode stage.
//
// Ports
//   clk        rising-edge clock
//   clr        asynchronous active-low reset
//   set        synchronous set: every entry becomes all-ones, busy cleared
//   ld_str     write enable
//   wr_addr    write address
//   wr_data    write data
//   rd_addr_a  read port A address
//   rd_addr_b  read port B address
//   rd_data_a  registered read data, port A (value the entry holds after the edge)
//   rd_data_b  registered read data, port B
//   lock_en    mark entry lock_addr busy (pending load)
//   lock_addr  entry to lock
//   busy_a     busy flag of entry rd_addr_a (combinational, no bypass)
//   busy_b     busy flag of entry rd_addr_b (combinational, no bypass)
// ---------------------------------------------------------------------------
module ld_str_reg_file #(
    parameter int              WIDTH     = 8,
    parameter int              DEPTH     = 8,
    parameter int              ADDR_W    = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit              ZERO_REG  = 1'b0
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              set,
    input  logic              ld_str,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_a,
    output logic [WIDTH-1:0]  rd_data_b,
    input  logic              lock_en,
    input  logic [ADDR_W-1:0] lock_addr,
    output logic              busy_a,
    output logic              busy_b
);

    // One extra bit so DEPTH == 2**ADDR_W is representable in the compare.
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

    logic              w_wr_ok;
    logic              w_lock_ok;
    logic [WIDTH-1:0]  w_entry [DEPTH];   // stored value of each entry
    logic              w_busy  [DEPTH];   // stored busy bit of each entry
    logic [WIDTH-1:0]  w_after [DEPTH];   // value each entry holds after this edge
    logic [WIDTH-1:0]  w_rd_next_a;
    logic [WIDTH-1:0]  w_rd_next_b;
    logic              w_busy_a;
    logic              w_busy_b;
    logic [WIDTH-1:0]  r_rd_a;
    logic [WIDTH-1:0]  r_rd_b;

    // Out-of-range addresses and the hard-wired zero entry never take writes or locks.
    assign w_wr_ok   = ld_str  && ({1'b0, wr_addr}   < DEPTH_W)
                               && !(ZERO_REG && (wr_addr == '0));
    assign w_lock_ok = lock_en && ({1'b0, lock_addr} < DEPTH_W)
                               && !(ZERO_REG && (lock_addr == '0));

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            if (ZERO_REG && (gi == 0)) begin : g_zero
                assign w_entry[gi] = '0;
                assign w_busy[gi]  = 1'b0;
                assign w_after[gi] = '0;
            end else begin : g_reg
                logic w_wr_hit;
                logic w_lock_hit;
                logic [WIDTH-1:0] r_mem;
                logic r_busy;

                assign w_wr_hit   = w_wr_ok   && (wr_addr   == ADDR_W'(gi));
                assign w_lock_hit = w_lock_ok && (lock_addr == ADDR_W'(gi));

                always_ff @(posedge clk or negedge clr) begin
                    if (!clr) begin
                        r_mem  <= RESET_VAL;
                        r_busy <= 1'b0;
                    end else if (set) begin
                        r_mem  <= '1;
                        r_busy <= 1'b0;
                    end else begin
                        if (w_wr_hit) begin
                            r_mem <= wr_data;
                        end
                        // A lock in the same cycle as the write wins: the new
                        // pending load keeps the entry busy.
                        if (w_lock_hit) begin
                            r_busy <= 1'b1;
                        end else if (w_wr_hit) begin
                            r_busy <= 1'b0;
                        end
                    end
                end

                assign w_entry[gi] = r_mem;
                assign w_busy[gi]  = r_busy;
                assign w_after[gi] = set      ? '1      :
                                     w_wr_hit ? wr_data : r_mem;
            end
        end
    endgenerate

    // Read muxes; addresses that match no entry return 0 / not busy.
    always_comb begin
        w_rd_next_a = '0;
        w_rd_next_b = '0;
        w_busy_a    = 1'b0;
        w_busy_b    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr_a == ADDR_W'(i)) begin
                w_rd_next_a = w_after[i];
                w_busy_a    = w_busy[i];
            end
            if (rd_addr_b == ADDR_W'(i)) begin
                w_rd_next_b = w_after[i];
                w_busy_b    = w_busy[i];
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_rd_a <= '0;
            r_rd_b <= '0;
        end else begin
            r_rd_a <= w_rd_next_a;
            r_rd_b <= w_rd_next_b;
        end
    end

    assign rd_data_a = r_rd_a;
    assign rd_data_b = r_rd_b;
    assign busy_a    = w_busy_a;
    assign busy_b    = w_busy_b;

endmodule

// File: tb/tb_ld_str_reg_file.sv
// ---------------------------------------------------------------------------
// tb_ld_str_reg_file
//
// Drives two instances from the same stimulus:
//   u_dut0: WIDTH=8, DEPTH=6, RESET_VAL=8'h5A, ZERO_REG=1
//   u_dut1: WIDTH=8, DEPTH=8, RESET_VAL=8'h5A, ZERO_REG=0
// Expected read data is pushed to a scoreboard queue when a cycle is driven
// and popped when the registered outputs appear.
// ---------------------------------------------------------------------------
module tb_ld_str_reg_file;

    logic       clk = 1'b0;
    logic       clr;
    logic       set;
    logic       ld_str;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic [2:0] rd_addr_a;
    logic [2:0] rd_addr_b;
    logic       lock_en;
    logic [2:0] lock_addr;

    logic [7:0] rda0, rdb0, rda1, rdb1;
    logic       ba0, bb0, ba1, bb1;

    always #5 clk = ~clk;

    ld_str_reg_file #(.WIDTH(8), .DEPTH(6), .ADDR_W(3), .RESET_VAL(8'h5A), .ZERO_REG(1'b1)) u_dut0 (
        .clk(clk), .clr(clr), .set(set), .ld_str(ld_str), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rda0), .rd_data_b(rdb0),
        .lock_en(lock_en), .lock_addr(lock_addr), .busy_a(ba0), .busy_b(bb0)
    );

    ld_str_reg_file #(.WIDTH(8), .DEPTH(8), .ADDR_W(3), .RESET_VAL(8'h5A), .ZERO_REG(1'b0)) u_dut1 (
        .clk(clk), .clr(clr), .set(set), .ld_str(ld_str), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rda1), .rd_data_b(rdb1),
        .lock_en(lock_en), .lock_addr(lock_addr), .busy_a(ba1), .busy_b(bb1)
    );

    // ---------------- reference model ----------------
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] m_mem  [2][8];
    bit         m_busy [2][8];
    int         m_dep  [2] = '{6, 8};
    bit         m_zr   [2] = '{1'b1, 1'b0};

    typedef struct {
        logic [7:0] a0;
        logic [7:0] b0;
        logic [7:0] a1;
        logic [7:0] b1;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_in(input int k, input logic [2:0] a);
        return int'(a) < m_dep[k];
    endfunction

    function automatic bit m_usable(input int k, input logic [2:0] a);
        return m_in(k, a) && !(m_zr[k] && a == 3'd0);
    endfunction

    // Value entry a holds after the coming edge, as seen by a read.
    function automatic logic [7:0] m_rd(input int k, input logic [2:0] a);
        if (!m_in(k, a))                         return 8'h00;
        if (m_zr[k] && a == 3'd0)                return 8'h00;
        if (set)                                 return 8'hFF;
        if (ld_str && m_usable(k, wr_addr) && wr_addr == a) return wr_data;
        return m_mem[k][a];
    endfunction

    function automatic bit m_bsy(input int k, input logic [2:0] a);
        return m_in(k, a) && m_busy[k][a];
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 8; i++) begin
                m_mem[k][i]  = (m_zr[k] && i == 0) ? 8'h00 : 8'h5A;
                m_busy[k][i] = 1'b0;
            end
    endtask

    task automatic m_update();
        for (int k = 0; k < 2; k++) begin
            if (set) begin
                for (int i = 0; i < m_dep[k]; i++) begin
                    m_mem[k][i]  = (m_zr[k] && i == 0) ? 8'h00 : 8'hFF;
                    m_busy[k][i] = 1'b0;
                end
            end else begin
                if (ld_str && m_usable(k, wr_addr)) begin
                    m_mem[k][wr_addr]  = wr_data;
                    m_busy[k][wr_addr] = 1'b0;
                end
                if (lock_en && m_usable(k, lock_addr))
                    m_busy[k][lock_addr] = 1'b1;
            end
        end
    endtask

    // One clock of stimulus; read data is checked through the scoreboard,
    // busy flags against the model state after the edge.
    task automatic do_cycle(input bit s, input bit ld, input logic [2:0] wa, input logic [7:0] wd,
                            input logic [2:0] ra, input logic [2:0] rb,
                            input bit le, input logic [2:0] la);
        exp_t e;
        exp_t g;
        set = s; ld_str = ld; wr_addr = wa; wr_data = wd;
        rd_addr_a = ra; rd_addr_b = rb; lock_en = le; lock_addr = la;
        e.a0 = m_rd(0, ra); e.b0 = m_rd(0, rb);
        e.a1 = m_rd(1, ra); e.b1 = m_rd(1, rb);
        sb.push_back(e);
        m_update();
        @(posedge clk);
        #1;
        g = sb.pop_front();
        $display("cyc t=%0t set=%0b ld=%0b wa=%0d wd=%0h ra=%0d rb=%0d lk=%0b la=%0d | d0 %0h/%0h d1 %0h/%0h",
                 $time, s, ld, wa, wd, ra, rb, le, la, rda0, rdb0, rda1, rdb1);
        chk("rd_a0", 32'(rda0), 32'(g.a0));
        chk("rd_b0", 32'(rdb0), 32'(g.b0));
        chk("rd_a1", 32'(rda1), 32'(g.a1));
        chk("rd_b1", 32'(rdb1), 32'(g.b1));
        chk("busy_a0", 32'(ba0), 32'(m_bsy(0, ra)));
        chk("busy_b0", 32'(bb0), 32'(m_bsy(0, rb)));
        chk("busy_a1", 32'(ba1), 32'(m_bsy(1, ra)));
        chk("busy_b1", 32'(bb1), 32'(m_bsy(1, rb)));
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_rd_a0"}, 32'(rda0), 32'h0);
        chk({tag, "_rd_b0"}, 32'(rdb0), 32'h0);
        chk({tag, "_rd_a1"}, 32'(rda1), 32'h0);
        chk({tag, "_rd_b1"}, 32'(rdb1), 32'h0);
        chk({tag, "_busy_a0"}, 32'(ba0), 32'h0);
        chk({tag, "_busy_a1"}, 32'(ba1), 32'h0);
        chk({tag, "_busy_b1"}, 32'(bb1), 32'h0);
    endtask

    initial begin
        clr = 1'b0; set = 1'b0; ld_str = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr_a = '0; rd_addr_b = '0; lock_en = 1'b0; lock_addr = '0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outs("por");
        clr = 1'b1;

        // First reads after release see RESET_VAL
        do_cycle(0, 0, 0, 8'h00, 3'd0, 3'd1, 0, 0);
        do_cycle(0, 0, 0, 8'h00, 3'd5, 3'd7, 0, 0);

        // Write then read next cycle
        do_cycle(0, 1, 3'd3, 8'hC3, 3'd0, 3'd1, 0, 0);
        do_cycle(0, 0, 0, 8'h00, 3'd3, 3'd1, 0, 0);
        // Same-cycle bypass on port B, both ports on the same entry
        do_cycle(0, 1, 3'd5, 8'h11, 3'd3, 3'd5, 0, 0);
        do_cycle(0, 0, 0, 8'h00, 3'd5, 3'd5, 0, 0);

        // Busy scoreboard on entry 4
        do_cycle(0, 0, 0, 8'h00, 3'd4, 3'd3, 1, 3'd4);
        do_cycle(0, 1, 3'd4, 8'h22, 3'd4, 3'd3, 0, 0);
        do_cycle(0, 1, 3'd4, 8'h33, 3'd4, 3'd4, 1, 3'd4);
        do_cycle(0, 0, 0, 8'h00, 3'd4, 3'd4, 0, 0);

        // Set beats write and lock to entry 2; entry 0 stays 0 with ZERO_REG
        do_cycle(0, 0, 0, 8'h00, 3'd2, 3'd0, 1, 3'd2);
        do_cycle(1, 1, 3'd2, 8'h00, 3'd2, 3'd0, 1, 3'd2);
        do_cycle(0, 0, 0, 8'h00, 3'd2, 3'd0, 0, 0);

        // Bounds: writes/locks at 6 and 7 only land in the DEPTH=8 instance
        do_cycle(0, 1, 3'd7, 8'hAA, 3'd6, 3'd7, 1, 3'd6);
        do_cycle(0, 1, 3'd6, 8'hAB, 3'd6, 3'd7, 1, 3'd7);
        do_cycle(0, 0, 0, 8'h00, 3'd6, 3'd7, 0, 0);
        do_cycle(0, 0, 0, 8'h00, 3'd1, 3'd5, 0, 0);

        // Entry 0: ignored with ZERO_REG, writable otherwise
        do_cycle(0, 1, 3'd0, 8'h99, 3'd0, 3'd0, 1, 3'd0);
        do_cycle(0, 0, 0, 8'h00, 3'd0, 3'd1, 0, 0);

        // Mid-cycle asynchronous reset with busy bits set
        do_cycle(0, 0, 0, 8'h00, 3'd3, 3'd4, 1, 3'd3);
        #2;
        clr = 1'b0;
        #1;
        chk_reset_outs("async");
        m_reset();
        @(posedge clk);
        #1;
        clr = 1'b1;
        do_cycle(0, 0, 0, 8'h00, 3'd3, 3'd4, 0, 0);
        do_cycle(0, 0, 0, 8'h00, 3'd7, 3'd0, 0, 0);

        // Reset held across an edge with a write in flight
        set = 1'b0; ld_str = 1'b1; wr_addr = 3'd1; wr_data = 8'h77;
        lock_en = 1'b1; lock_addr = 3'd1; rd_addr_a = 3'd1; rd_addr_b = 3'd1;
        #1;
        clr = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_outs("midop");
        m_reset();
        ld_str = 1'b0; lock_en = 1'b0;
        clr = 1'b1;
        do_cycle(0, 0, 0, 8'h00, 3'd1, 3'd2, 0, 0);

        // Random traffic
        for (int n = 0; n < 60; n++) begin
            do_cycle(($urandom % 16) == 0, $urandom % 2, 3'($urandom), 8'($urandom),
                     3'($urandom), 3'($urandom), $urandom % 2, 3'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
